// File: rtl/pwm_bank.sv
// pwm_bank: a bank of PWM channels that share one counter.
// Configuration is double-buffered: requests land in a shadow copy. The
// shadow moves into the active copy at a period boundary, or at once while
// the counter is stopped. Edge-aligned and center-aligned modes are supported.

// Per-channel compare stage: a registered gate of the unmodulated input.
module pwm_bank_lane #(
  parameter int CtrSize = 8
) (
  input  logic               clk_sys_i,
  input  logic               rst_sys_i,
  input  logic               en_i,
  input  logic               unmod_i,
  input  logic [CtrSize-1:0] ctr_i,
  input  logic [CtrSize-1:0] duty_i,
  output logic               mod_o
);
  logic r_mod;

  // Output is high while the counter is below the duty value; forced low while stopped.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) r_mod <= 1'b0;
    else           r_mod <= en_i & unmod_i & (ctr_i < duty_i);
  end

  assign mod_o = r_mod;
endmodule

module pwm_bank #(
  parameter int NumChannels = 4,
  parameter int CtrSize     = 8
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_sys_i,
  input  logic                           en_i,
  input  logic                           upd_req_i,
  input  logic                           center_i,
  input  logic [CtrSize-1:0]             period_i,
  input  logic [NumChannels*CtrSize-1:0] duty_i,
  input  logic [NumChannels-1:0]         unmodulated_i,
  output logic [NumChannels-1:0]         modulated_o,
  output logic                           pending_o,
  output logic                           period_end_o
);
  logic [CtrSize-1:0]                    r_ctr;
  logic                                  r_down;
  logic                                  r_act_center, r_sh_center;
  logic [CtrSize-1:0]                    r_act_per, r_sh_per;
  logic [NumChannels-1:0][CtrSize-1:0]   r_act_duty, r_sh_duty;
  logic                                  r_pending;
  logic                                  r_period_end;
  logic                                  w_bnd;
  logic                                  w_load;

  // A boundary is the last cycle of a period, where the counter's next value is 0.
  always_comb begin
    w_bnd = 1'b0;
    if (r_act_per == '0)                    w_bnd = 1'b1;
    else if (!r_act_center)                 w_bnd = (r_ctr == r_act_per);
    else if (r_act_per == CtrSize'(1))      w_bnd = (r_ctr == r_act_per);
    else                                    w_bnd = r_down && (r_ctr == CtrSize'(1));
  end

  // The shadow is applied at a boundary while running, or immediately while stopped.
  assign w_load = r_pending & (~en_i | w_bnd);

  // Shared counter: up-wrap in edge mode, up/down triangle in center mode.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i || !en_i || w_bnd) begin
      r_ctr  <= '0;
      r_down <= 1'b0;
    end else if (r_down) begin
      r_ctr  <= r_ctr - CtrSize'(1);
    end else if (r_act_center && r_ctr == r_act_per) begin
      r_ctr  <= r_act_per - CtrSize'(1);
      r_down <= 1'b1;
    end else begin
      r_ctr  <= r_ctr + CtrSize'(1);
    end
  end

  // Double-buffered configuration. A request that arrives in a load cycle goes
  // to the shadow and stays pending for the next boundary.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      r_act_center <= 1'b0;
      r_act_per    <= '1;
      r_act_duty   <= '0;
      r_sh_center  <= 1'b0;
      r_sh_per     <= '1;
      r_sh_duty    <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (w_load) begin
        r_act_center <= r_sh_center;
        r_act_per    <= r_sh_per;
        r_act_duty   <= r_sh_duty;
      end
      if (upd_req_i) begin
        r_sh_center <= center_i;
        r_sh_per    <= period_i;
        r_sh_duty   <= duty_i;
      end
      r_pending <= upd_req_i | (r_pending & ~w_load);
    end
  end

  // One-cycle pulse after each boundary cycle while running.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) r_period_end <= 1'b0;
    else           r_period_end <= en_i & w_bnd;
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_lane
    pwm_bank_lane #(.CtrSize(CtrSize)) u_lane (
      .clk_sys_i (clk_sys_i),
      .rst_sys_i (rst_sys_i),
      .en_i      (en_i),
      .unmod_i   (unmodulated_i[g]),
      .ctr_i     (r_ctr),
      .duty_i    (r_act_duty[g]),
      .mod_o     (modulated_o[g])
    );
  end

  assign pending_o    = r_pending;
  assign period_end_o = r_period_end;
endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank (4 channels, 8-bit counter). Each window of
// cycles counts the high cycles per channel and the period_end pulses, and
// compares them with hand-computed values.
module tb_pwm_bank;
  logic        clk_sys_i = 1'b0;
  logic        rst_sys_i = 1'b1;
  logic        en_i = 1'b0;
  logic        upd_req_i = 1'b0;
  logic        center_i = 1'b0;
  logic [7:0]  period_i = '0;
  logic [31:0] duty_i = '0;
  logic [3:0]  unmodulated_i = 4'hF;
  logic [3:0]  modulated_o;
  logic        pending_o;
  logic        period_end_o;

  int   n_chk = 0;
  int   n_pass = 0;
  int   hi[4];
  int   pe_cnt, pe_idx;
  logic pend_first, pend_last;
  logic mod_or;

  pwm_bank #(.NumChannels(4), .CtrSize(8)) dut (
    .clk_sys_i     (clk_sys_i),
    .rst_sys_i     (rst_sys_i),
    .en_i          (en_i),
    .upd_req_i     (upd_req_i),
    .center_i      (center_i),
    .period_i      (period_i),
    .duty_i        (duty_i),
    .unmodulated_i (unmodulated_i),
    .modulated_o   (modulated_o),
    .pending_o     (pending_o),
    .period_end_o  (period_end_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  // Present a configuration request; it is held for exactly one clock edge.
  task automatic req(input logic c, input logic [7:0] p,
                     input logic [7:0] d0, input logic [7:0] d1,
                     input logic [7:0] d2, input logic [7:0] d3);
    center_i  = c;
    period_i  = p;
    duty_i    = {d3, d2, d1, d0};
    upd_req_i = 1'b1;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    pe_cnt = 0;
    pe_idx = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_sys_i); #1;
      upd_req_i = 1'b0;
      for (int c = 0; c < 4; c++) hi[c] += int'(modulated_o[c]);
      if (period_end_o) begin
        pe_cnt++;
        if (pe_idx < 0) pe_idx = k;
      end
      if (k == 0) pend_first = pending_o;
      pend_last = pending_o;
    end
  endtask

  initial begin
    // Reset state.
    run(2);
    chk("rst_mod", int'(modulated_o), 0);
    chk("rst_pend", int'(pending_o), 0);
    chk("rst_pe", int'(period_end_o), 0);

    // Edge mode P=9, D={0,3,10,255}; applied immediately while stopped.
    rst_sys_i = 1'b0;
    req(1'b0, 8'd9, 8'd0, 8'd3, 8'd10, 8'd255);
    run(1);
    chk("edge_pend_set", int'(pend_last), 1);
    run(1);
    chk("edge_pend_clr_stopped", int'(pend_last), 0);
    chk("edge_mod_stopped", int'(modulated_o), 0);
    en_i = 1'b1;
    for (int w = 0; w < 2; w++) begin
      run(10);
      chk("edge_hi0", hi[0], 0);
      chk("edge_hi1", hi[1], 3);
      chk("edge_hi2", hi[2], 10);
      chk("edge_hi3", hi[3], 10);
      chk("edge_pe_cnt", pe_cnt, 1);
      chk("edge_pe_idx", pe_idx, 9);
    end

    // Double buffer: D0=5 runs, a mid-period change to 2 waits for the boundary.
    req(1'b0, 8'd9, 8'd5, 8'd3, 8'd10, 8'd255);
    run(10);
    chk("dbuf_old_hi0", hi[0], 0);
    chk("dbuf_pend_first", int'(pend_first), 1);
    chk("dbuf_pend_last", int'(pend_last), 0);
    run(10);
    chk("dbuf_d5_hi0", hi[0], 5);
    run(4);
    chk("dbuf_part_a", hi[0], 4);
    req(1'b0, 8'd9, 8'd2, 8'd3, 8'd10, 8'd255);
    run(6);
    chk("dbuf_part_b", hi[0], 1);
    chk("dbuf_mid_pend", int'(pend_first), 1);
    chk("dbuf_mid_pend_clr", int'(pend_last), 0);
    run(10);
    chk("dbuf_d2_hi0", hi[0], 2);

    // Request on the boundary cycle (D=7), then D=1 on the next cycle.
    run(9);
    chk("bnd_pre_hi0", hi[0], 2);
    req(1'b0, 8'd9, 8'd7, 8'd3, 8'd10, 8'd255);
    run(1);
    chk("bnd_pe", pe_cnt, 1);
    chk("bnd_pend_kept", int'(pend_last), 1);
    req(1'b0, 8'd9, 8'd1, 8'd3, 8'd10, 8'd255);
    run(10);
    chk("bnd_still_old", hi[0], 2);
    chk("bnd_pend_clr", int'(pend_last), 0);
    run(10);
    chk("bnd_latest_wins", hi[0], 1);

    // Center mode P=4, D={2,3,5,0}: 8-cycle period, high 3/5/8/0.
    req(1'b1, 8'd4, 8'd2, 8'd3, 8'd5, 8'd0);
    run(10);
    chk("ctr_last_edge_hi0", hi[0], 1);
    for (int w = 0; w < 2; w++) begin
      run(8);
      chk("ctr_hi0", hi[0], 3);
      chk("ctr_hi1", hi[1], 5);
      chk("ctr_hi2", hi[2], 8);
      chk("ctr_hi3", hi[3], 0);
      chk("ctr_pe_cnt", pe_cnt, 1);
      chk("ctr_pe_idx", pe_idx, 7);
    end

    // Disable with a pending edge-mode P=3 update.
    req(1'b0, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0);
    run(1);
    chk("dis_pend_set", int'(pend_last), 1);
    en_i = 1'b0;
    run(1);
    chk("dis_pend_clr", int'(pend_last), 0);
    chk("dis_mod", int'(modulated_o), 0);
    chk("dis_pe", pe_cnt, 0);
    run(2);
    chk("dis_hold_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    en_i = 1'b1;
    for (int w = 0; w < 2; w++) begin
      run(4);
      chk("en_hi0", hi[0], 2);
      chk("en_pe_cnt", pe_cnt, 1);
      chk("en_pe_idx", pe_idx, 3);
    end

    // Reset mid-period with an update pending.
    run(2);
    req(1'b0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3);
    run(1);
    chk("rst2_pend_set", int'(pend_last), 1);
    rst_sys_i = 1'b1;
    run(1);
    chk("rst2_mod", int'(modulated_o), 0);
    chk("rst2_pend", int'(pend_last), 0);
    chk("rst2_pe", int'(period_end_o), 0);
    rst_sys_i = 1'b0;
    mod_or = 1'b0;
    pe_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      unmodulated_i = (k % 2 == 0) ? 4'h5 : 4'hA;
      @(posedge clk_sys_i); #1;
      mod_or |= |modulated_o;
      if (period_end_o) pe_cnt++;
    end
    chk("rst2_duty_zero", int'(mod_or), 0);
    chk("rst2_shadow_gone", int'(pending_o), 0);
    chk("rst2_period_max", pe_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
